systolic_pe: RTL

Parametrised output-stationary processing element for the systolic-array datapath, the successor of the fixed int8 MAC cell. Each cell forwards its A and B operands with valid bits to its east and south neighbours. It accumulates signed products into a saturating wide accumulator and converts the result to a rounded, saturated output word. Results leave the array column through a shift chain that runs in parallel with accumulation, so one tile can drain while the next tile computes.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/pe_normalize.sv | 33 +++
 rtl/systolic_pe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared default widths, saturation bounds and datapath types for the systolic PE
package systolic_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 24;
  localparam int OUT_W_DEF  = 8;
  localparam int SHIFT_DEF  = 4;
  localparam int CNT_W_DEF  = 16;

  typedef logic signed [DATA_W_DEF-1:0] operand_t;
  typedef logic signed [ACC_W_DEF-1:0]  acc_t;
  typedef logic signed [OUT_W_DEF-1:0]  result_t;

  // Largest and smallest values of a w-bit two's complement word.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/pe_normalize.sv
// rtl/pe_normalize.sv - round-half-up, arithmetic shift and saturate an accumulator to the result width
module pe_normalize
  import systolic_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic signed [ACC_W-1:0] acc_in,
  output logic signed [OUT_W-1:0] res_out
);

  // One extra bit so the rounding addend never wraps the most positive accumulator.
  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'((longint'(1) <<< SHIFT) >>> 1);
  localparam logic signed [ACC_W:0] HI   = (ACC_W+1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] LO   = (ACC_W+1)'(sat_min(OUT_W));

  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    rounded = (ACC_W+1)'(acc_in) + HALF;
    shifted = rounded >>> SHIFT;
    if (shifted > HI) begin
      res_out = OUT_W'(HI);
    end else if (shifted < LO) begin
      res_out = OUT_W'(LO);
    end else begin
      res_out = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - output-stationary PE: operand forwarding, saturating MAC, capture/shift result chain
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic                     a_vld_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic                     b_vld_in,
  input  logic                     acc_clr,
  input  logic                     capture,
  input  logic                     shift_en,
  input  logic signed [OUT_W-1:0]  res_in,
  input  logic                     res_vld_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic                     a_vld_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic                     b_vld_out,
  output logic signed [OUT_W-1:0]  res_out,
  output logic                     res_vld_out,
  output logic                     ovf,
  output logic [CNT_W-1:0]         mac_cnt
);

  localparam logic signed [ACC_W:0] SUM_MAX = (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] SUM_MIN = (ACC_W+1)'(sat_min(ACC_W));

  logic signed [DATA_W-1:0]   a_d, a_q, b_d, b_q;
  logic                       a_vld_d, a_vld_q, b_vld_d, b_vld_q;
  logic signed [ACC_W-1:0]    acc_d, acc_q, acc_base;
  logic                       ovf_d, ovf_q;
  logic [CNT_W-1:0]           cnt_d, cnt_q;
  logic signed [OUT_W-1:0]    res_d, res_q, norm;
  logic                       res_vld_d, res_vld_q;
  logic                       mac;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W:0]      sum;

  // Capture sees the registered accumulator, so a same-cycle MAC is excluded from the result.
  pe_normalize #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_norm (
    .acc_in  (acc_q),
    .res_out (norm)
  );

  always_comb begin
    a_d      = a_in;
    a_vld_d  = a_vld_in;
    b_d      = b_in;
    b_vld_d  = b_vld_in;

    mac      = a_vld_in & b_vld_in;
    prod     = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);
    acc_base = acc_clr ? '0 : acc_q;
    sum      = (ACC_W+1)'(acc_base) + (ACC_W+1)'(prod);

    acc_d    = acc_base;
    ovf_d    = ovf_q & ~acc_clr;
    cnt_d    = acc_clr ? '0 : cnt_q;
    if (mac) begin
      if (sum > SUM_MAX) begin
        acc_d = SUM_MAX[ACC_W-1:0];
        ovf_d = 1'b1;
      end else if (sum < SUM_MIN) begin
        acc_d = SUM_MIN[ACC_W-1:0];
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
      if (cnt_d != '1) begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end

    res_d     = res_q;
    res_vld_d = res_vld_q;
    if (capture) begin
      res_d     = norm;
      res_vld_d = 1'b1;
    end else if (shift_en) begin
      res_d     = res_in;
      res_vld_d = res_vld_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      a_vld_q   <= 1'b0;
      b_q       <= '0;
      b_vld_q   <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      a_vld_q   <= a_vld_d;
      b_q       <= b_d;
      b_vld_q   <= b_vld_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign a_out       = a_q;
  assign a_vld_out   = a_vld_q;
  assign b_out       = b_q;
  assign b_vld_out   = b_vld_q;
  assign res_out     = res_q;
  assign res_vld_out = res_vld_q;
  assign ovf         = ovf_q;
  assign mac_cnt     = cnt_q;

endmodule
